keccak_absorb_front: RTL and testbench
======================================

# keccak_absorb_front

Front end of the Keccak absorb path. It collects 64-bit message words into a rate-sized block and applies SHA-3/SHAKE multi-rate padding. It flattens the incoming 5×5×64 state array to a 1600-bit string and XORs the block into that string. It sits between the host word stream and the round-function pipeline register.

## Interface
Parameters:
- none; all constants come from `keccak_pkg`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-high (the name is kept for codebase consistency).
- `dt_i` in 64: message word; lane bits little-endian.
- `valid_i` in 1: `dt_i` is presented this cycle.
- `last_i` in 1: the current valid word is the final message word.
- `cmode` in 3: mode select.
  - 0 = SHA3-224, rate 1152 bits, 18 words
  - 1 = SHA3-256, rate 1088, 17 words
  - 2 = SHA3-384, rate 832, 13 words
  - 3 = SHA3-512, rate 576, 9 words
  - 4 = SHAKE128, rate 1344, 21 words
  - 5 = SHAKE256, rate 1088, 17 words
  - 6–7 are illegal.
- `en_vsx` in 1: enables the XOR of the block into the state.
- `state_i` in `keccak_pkg::state`: current state, indexed `[x][y][z]`.
- `ready_o` out 1: a word is accepted this cycle.
- `block_o` out 1344: current block. Word i occupies bits `[64i+63:64i]`; bits above the rate are 0.
- `block_full_o` out 1: one-cycle pulse when `block_o` holds a new complete block.
- `first_o` out 1: the current block is the first block of its message.
- `final_o` out 1: the current block is the last (padded) block of its message.
- `state_str_o` out 1600: flattened `state_i`.
- `absorbed_o` out 1600: value to feed the round-function pipeline register.

## Operation
- **Word acceptance:** a word is accepted when `valid_i` and `ready_o` are both high. It is written into word slot `cnt`, then `cnt` increments.
- **Mode latch:** `cmode` is latched on the first word of each message. Changes mid-message are ignored.
- **Block completion without last word:** when `cnt` reaches the word count for the mode, the block is complete and `cnt` wraps to 0.
- **Last word, block not yet filled:** padding is inserted in the same cycle.
  - Word `cnt+1` is set to the domain byte: `0x06` for SHA3, `0x1F` for SHAKE.
  - The final rate word has bit 63 set; if it is the same word as the domain word, the two are ORed.
  - All intermediate words are 0.
- **Last word fills the block exactly:** the block completes normally. On the next cycle an extra block is issued containing only the padding, with `final_o` set; `ready_o` is low during that cycle.
- **Mode 5 with last word in slot 15:** the domain word lands in slot 16 and is ORed with bit 63, giving `0x800000000000001F`.
- **Block flags:** `first_o` is set on the first block after reset or after a final block. `final_o` is set only on the padded block.
- **Holding:** `block_o`, `first_o` and `final_o` hold until the next `block_full_o`.
- **Flatten:** `state_str_o[64*(5y+x)+z] = state_i[x][y][z]`.
- **XOR:** `absorbed_o = en_vsx ? state_str_o ^ {256'b0, block_o} : state_str_o`. This path is combinational.

## Timing
- **Reset:**
  - `cnt` = 0
  - `block_o` = 0
  - `block_full_o`, `first_o`, `final_o` = 0
  - `ready_o` = 1
  - latched mode = 3
- **Block latency:** a word accepted at edge k that completes a block gives `block_full_o` = 1 during cycle k+1.
- **Extra padding block:** when needed, it pulses at k+2.
- **Combinational outputs:** `absorbed_o` and `state_str_o` have zero latency.
- **Reset mid-message:** the partial block is discarded and no `block_full_o` is produced.
- **`last_i` without `valid_i`:** ignored.

## Configuration
- `KECCAK_SHAKE_EN` defined: modes 4 and 5 are supported.
- Not defined: modes 4–7 are illegal. An illegal mode is handled as follows:
  - Words are accepted, with `ready_o` high.
  - They are dropped; no block and no `block_full_o` is produced.
  - `block_o` is unchanged.

## Structure
- `keccak_pkg` holds:
  - the `plane` and `state` typedefs
  - `N = 64`
  - the rate and word-count table per mode
  - the domain bytes
- One sub-module, `state_flatten` (array → string), is natural. Buffering, padding and the XOR stay in the top.

## Test plan
- **SHA3-512 single-word message:** mode 3, one word `0xFFFFFFFFFFFFFFFF` with `last_i` = 1.
  - Next cycle: `block_full_o` = 1, `first_o` = 1, `final_o` = 1.
  - Word0 = all-ones, word1 = `0x06`, word8 = `0x8000000000000000`, all other words 0.
- **SHA3-512, nine words of all-ones, last on word 9:**
  - Block 1: all nine words are ones; `first_o` = 1, `final_o` = 0.
  - Block 2 one cycle later: word0 = `0x06`, word8 = `0x8000000000000000`; `ready_o` low for that cycle.
- **SHAKE256 single zero word** (macro defined): word1 = `0x1F`, word16 = `0x8000000000000000`.
  - With the macro undefined: no `block_full_o` is produced.
- **Flatten and XOR:** `state_i[1][0]` = `0x1234`, everything else 0.
  - `en_vsx` = 0: `absorbed_o[127:64]` = `0x1234`, `absorbed_o[63:0]` = 0.
  - `en_vsx` = 1 with the single-word SHA3-512 block: bits `[127:64]` = `0x1232`, bits `[63:0]` = all-ones.
- **Reset after 4 words, then a one-word SHA3-512 message:**
  - No `block_full_o` is produced for the discarded partial block.
  - The new message gives the same block as the first scenario.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak absorb-path types, lane width, per-mode rate table and domain bytes.
package keccak_pkg;

    localparam int unsigned N        = 64;
    localparam int unsigned MaxWords = 21;

    typedef logic [4:0][N-1:0] plane;
    typedef plane [4:0]        state;
    typedef logic [MaxWords-1:0][N-1:0] block_t;

    typedef enum logic {StAccept, StPad} front_st_e;

    localparam logic [2:0]   ModeReset = 3'd3;
    localparam logic [N-1:0] DomSha3   = 64'h06;
    localparam logic [N-1:0] DomShake  = 64'h1F;
    localparam logic [N-1:0] PadEnd    = {1'b1, 63'b0};

    function automatic logic [10:0] mode_rate(input logic [2:0] mode);
        case (mode)
            3'd0:    mode_rate = 11'd1152;
            3'd1:    mode_rate = 11'd1088;
            3'd2:    mode_rate = 11'd832;
            3'd3:    mode_rate = 11'd576;
            3'd4:    mode_rate = 11'd1344;
            3'd5:    mode_rate = 11'd1088;
            default: mode_rate = 11'd0;
        endcase
    endfunction

    function automatic logic [4:0] mode_words(input logic [2:0] mode);
        logic [10:0] rate;
        rate = mode_rate(mode);
        mode_words = rate[10:6];
    endfunction

    function automatic logic [N-1:0] mode_domain(input logic [2:0] mode);
        mode_domain = (mode >= 3'd4) ? DomShake : DomSha3;
    endfunction

endpackage

// File: rtl/state_flatten.sv
// Flattens the [x][y][z] Keccak state array into the 1600-bit lane string.
module state_flatten
    import keccak_pkg::*;
(
    input  state          state_i,
    output logic [1599:0] str_o
);

    always_comb begin
        str_o = '0;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                str_o[64*(5*y+x) +: 64] = state_i[x][y];
            end
        end
    end

endmodule

// File: rtl/keccak_absorb_front.sv
// Keccak absorb front end: word buffering, multi-rate padding, state flatten and block XOR.
// SHAKE modes 4 and 5 are accepted only when KECCAK_SHAKE_EN is defined.
module keccak_absorb_front
    import keccak_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [63:0]    dt_i,
    input  logic           valid_i,
    input  logic           last_i,
    input  logic [2:0]     cmode,
    input  logic           en_vsx,
    input  state           state_i,
    output logic           ready_o,
    output logic [1343:0]  block_o,
    output logic           block_full_o,
    output logic           first_o,
    output logic           final_o,
    output logic [1599:0]  state_str_o,
    output logic [1599:0]  absorbed_o
);

    front_st_e   r_st, w_st_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt;
    block_t      r_buf, w_buf_nxt;
    block_t      r_block, w_block_nxt;
    logic        r_full, w_full_nxt;
    logic        r_first, w_first_nxt;
    logic        r_final, w_final_nxt;
    logic        r_first_pend, w_first_pend_nxt;
    logic [2:0]  r_mode, w_mode_nxt;
    logic        r_in_msg, w_in_msg_nxt;

    logic [2:0]     w_mode;
    logic [4:0]     w_words, w_last_slot, w_cnt_inc, w_pad_slot;
    logic           w_legal, w_accept, w_at_end;
    block_t         w_fill, w_padded, w_pad_only;
    logic [1599:0]  w_state_str;

    state_flatten u_flatten (
        .state_i (state_i),
        .str_o   (w_state_str)
    );

    // Mode is taken live on the first word of a message, from the latch afterwards.
    assign w_mode = r_in_msg ? r_mode : cmode;

`ifdef KECCAK_SHAKE_EN
    assign w_legal = (w_mode <= 3'd5);
`else
    assign w_legal = (w_mode <= 3'd3);
`endif

    assign ready_o  = (r_st == StAccept);
    assign w_accept = valid_i & ready_o;

    always_comb begin
        w_words     = mode_words(w_mode);
        w_last_slot = w_words - 5'd1;
        w_cnt_inc   = r_cnt + 5'd1;
        w_at_end    = (r_cnt == w_last_slot);

        w_fill        = r_buf;
        w_fill[r_cnt] = dt_i;

        // Domain word and end bit may coincide; OR keeps both.
        w_padded = w_fill;
        if (!w_at_end) begin
            w_padded[w_cnt_inc]   = w_padded[w_cnt_inc] | mode_domain(w_mode);
            w_padded[w_last_slot] = w_padded[w_last_slot] | PadEnd;
        end

        w_pad_slot              = mode_words(r_mode) - 5'd1;
        w_pad_only              = '0;
        w_pad_only[0]           = mode_domain(r_mode);
        w_pad_only[w_pad_slot]  = w_pad_only[w_pad_slot] | PadEnd;
    end

    always_comb begin
        w_st_nxt         = r_st;
        w_cnt_nxt        = r_cnt;
        w_buf_nxt        = r_buf;
        w_block_nxt      = r_block;
        w_full_nxt       = 1'b0;
        w_first_nxt      = r_first;
        w_final_nxt      = r_final;
        w_first_pend_nxt = r_first_pend;
        w_mode_nxt       = r_mode;
        w_in_msg_nxt     = r_in_msg;

        unique case (r_st)
            StPad: begin
                w_block_nxt      = w_pad_only;
                w_full_nxt       = 1'b1;
                w_first_nxt      = r_first_pend;
                w_final_nxt      = 1'b1;
                w_first_pend_nxt = 1'b1;
                w_st_nxt         = StAccept;
            end
            StAccept: begin
                if (w_accept) begin
                    w_in_msg_nxt = ~last_i;
                    w_mode_nxt   = w_mode;
                    if (w_legal) begin
                        if (w_at_end || last_i) begin
                            w_block_nxt      = (last_i && !w_at_end) ? w_padded : w_fill;
                            w_full_nxt       = 1'b1;
                            w_first_nxt      = r_first_pend;
                            w_final_nxt      = last_i && !w_at_end;
                            w_first_pend_nxt = last_i && !w_at_end;
                            w_buf_nxt        = '0;
                            w_cnt_nxt        = 5'd0;
                            // Exactly-full last block needs a padding-only follow-up.
                            if (last_i && w_at_end) w_st_nxt = StPad;
                        end else begin
                            w_buf_nxt = w_fill;
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end
                end
            end
            default: w_st_nxt = StAccept;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_st         <= StAccept;
            r_cnt        <= 5'd0;
            r_buf        <= '0;
            r_block      <= '0;
            r_full       <= 1'b0;
            r_first      <= 1'b0;
            r_final      <= 1'b0;
            r_first_pend <= 1'b1;
            r_mode       <= ModeReset;
            r_in_msg     <= 1'b0;
        end else begin
            r_st         <= w_st_nxt;
            r_cnt        <= w_cnt_nxt;
            r_buf        <= w_buf_nxt;
            r_block      <= w_block_nxt;
            r_full       <= w_full_nxt;
            r_first      <= w_first_nxt;
            r_final      <= w_final_nxt;
            r_first_pend <= w_first_pend_nxt;
            r_mode       <= w_mode_nxt;
            r_in_msg     <= w_in_msg_nxt;
        end
    end

    assign block_o      = r_block;
    assign block_full_o = r_full;
    assign first_o      = r_first;
    assign final_o      = r_final;
    assign state_str_o  = w_state_str;
    assign absorbed_o   = en_vsx ? (w_state_str ^ {256'b0, block_o}) : w_state_str;

endmodule

// File: tb/tb_keccak_absorb_front.sv
// Scoreboard bench for keccak_absorb_front; SHAKE cases depend on KECCAK_SHAKE_EN.
module tb_keccak_absorb_front;
    import keccak_pkg::*;

    typedef logic [20:0][63:0] blk_t;
    typedef struct {
        blk_t blk;
        logic first;
        logic fin;
        int   id;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   dt_i;
    logic          valid_i, last_i, en_vsx;
    logic [2:0]    cmode;
    state          state_i;
    logic          ready_o, block_full_o, first_o, final_o;
    logic [1343:0] block_o;
    logic [1599:0] state_str_o, absorbed_o;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];
    exp_t m_e;
    blk_t m_got;
    blk_t last_blk;

    always #5 clk = ~clk;

    keccak_absorb_front dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dt_i         (dt_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .cmode        (cmode),
        .en_vsx       (en_vsx),
        .state_i      (state_i),
        .ready_o      (ready_o),
        .block_o      (block_o),
        .block_full_o (block_full_o),
        .first_o      (first_o),
        .final_o      (final_o),
        .state_str_o  (state_str_o),
        .absorbed_o   (absorbed_o)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t got, input blk_t want);
        int d;
        d = -1;
        total++;
        for (int i = 20; i >= 0; i--) if (got[i] !== want[i]) d = i;
        if (d >= 0) begin
            bad++;
            $display("FAIL %s: word %0d got %h want %h", nm, d, got[d], want[d]);
        end
    endtask

    task automatic push(input blk_t b, input logic f, input logic l, input int id);
        exp_t e;
        e.blk = b; e.first = f; e.fin = l; e.id = id;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [63:0] w, input logic last, input logic [2:0] m);
        int n;
        n = 0;
        while (!ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready_o) chk("ready_timeout", {63'b0, ready_o}, 64'd1);
        dt_i = w; last_i = last; cmode = m; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; last_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n && block_full_o) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_block: got block_full_o=1 want no block");
            end else begin
                m_e   = exp_q.pop_front();
                m_got = block_o;
                chk_blk($sformatf("block%0d", m_e.id), m_got, m_e.blk);
                chk($sformatf("first%0d", m_e.id), {63'b0, first_o}, {63'b0, m_e.first});
                chk($sformatf("final%0d", m_e.id), {63'b0, final_o}, {63'b0, m_e.fin});
            end
        end
    end

    blk_t b;
    blk_t s1;

    initial begin
        rst_n = 1'b1; valid_i = 1'b0; last_i = 1'b0; dt_i = '0;
        cmode = 3'd3; en_vsx = 1'b0; state_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        b = '0;
        chk("rst_ready", {63'b0, ready_o}, 64'd1);
        chk("rst_full", {63'b0, block_full_o}, 64'd0);
        chk("rst_first", {63'b0, first_o}, 64'd0);
        chk("rst_final", {63'b0, final_o}, 64'd0);
        chk_blk("rst_block", block_o, b);

        // SHA3-512 single all-ones word
        s1 = '0; s1[0] = '1; s1[1] = 64'h06; s1[8] = 64'h8000000000000000;
        push(s1, 1'b1, 1'b1, 1);
        send('1, 1'b1, 3'd3);

        // SHA3-512 nine words; cmode changes after the first word must be ignored
        b = '0;
        for (int i = 0; i < 9; i++) b[i] = '1;
        push(b, 1'b1, 1'b0, 2);
        b = '0; b[0] = 64'h06; b[8] = 64'h8000000000000000;
        push(b, 1'b0, 1'b1, 3);
        last_blk = b;
        for (int i = 0; i < 9; i++) send('1, i == 8, (i == 0) ? 3'd3 : 3'd0);
        chk("pad_ready_low", {63'b0, ready_o}, 64'd0);
        @(posedge clk); #1;
        chk("pad_ready_back", {63'b0, ready_o}, 64'd1);

        // SHA3-384, last in slot 11: domain and end bit share slot 12
        b = '0;
        for (int i = 0; i < 12; i++) b[i] = 64'(i + 1);
        b[12] = 64'h8000000000000006;
        push(b, 1'b1, 1'b1, 4);
        for (int i = 0; i < 12; i++) send(64'(i + 1), i == 11, 3'd2);

        // SHAKE256 single zero word
`ifdef KECCAK_SHAKE_EN
        b = '0; b[1] = 64'h1F; b[16] = 64'h8000000000000000;
        push(b, 1'b1, 1'b1, 5);
        send('0, 1'b1, 3'd5);
        b = '0;
        for (int i = 0; i < 15; i++) b[i] = 64'h100 + 64'(i);
        b[15] = 64'hABCD;
        b[16] = 64'h800000000000001F;
        push(b, 1'b1, 1'b1, 6);
        for (int i = 0; i < 15; i++) send(64'h100 + 64'(i), 1'b0, 3'd5);
        send(64'hABCD, 1'b1, 3'd5);
`else
        last_blk = b;
        send('0, 1'b1, 3'd5);
        repeat (4) @(posedge clk);
        #1;
        chk_blk("illegal_hold", block_o, last_blk);
`endif

        // Flatten and XOR
        repeat (3) @(posedge clk);
        #1;
        state_i = '0;
        state_i[1][0] = 64'h1234;
        push(s1, 1'b1, 1'b1, 7);
        send('1, 1'b1, 3'd3);
        en_vsx = 1'b0;
        #1;
        chk("str_lane1", state_str_o[127:64], 64'h1234);
        chk("abs_off_hi", absorbed_o[127:64], 64'h1234);
        chk("abs_off_lo", absorbed_o[63:0], 64'h0);
        en_vsx = 1'b1;
        #1;
        chk("abs_on_hi", absorbed_o[127:64], 64'h1232);
        chk("abs_on_lo", absorbed_o[63:0], 64'hFFFFFFFFFFFFFFFF);
        chk("abs_on_w8", absorbed_o[575:512], 64'h8000000000000000);
        en_vsx = 1'b0;
        state_i = '0;

        // Reset mid-message drops the partial block
        for (int i = 0; i < 4; i++) send(64'h55, 1'b0, 3'd3);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_ready", {63'b0, ready_o}, 64'd1);
        chk("rst2_first", {63'b0, first_o}, 64'd0);
        push(s1, 1'b1, 1'b1, 8);
        send('1, 1'b1, 3'd3);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
